execute: RTL and testbench
==========================

# execute

Execute stage of the bexkat1 pipeline, between register read/decode and the memory stage. It computes ALU results, effective addresses for loads and stores, and condition codes for compares. It also runs iterative 32-cycle unsigned multiply, divide and modulo, stalling upstream while busy. All outputs are registered and feed the memory stage directly.

## Interface
- No parameters.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ir_i  in  64  instruction; type ir_i[31:28], op ir_i[27:24], long-form flag ir_i[0]; type codes from bexkat1Def (T_ALU, T_CMP, T_MD, T_LOAD, T_STORE)
- pc_i  in  32  instruction PC
- reg_write_i  in  2  writeback control, passed through
- reg_data1_i  in  32  operand A / store data
- reg_data2_i  in  32  operand B / address base
- stall_i  in  1  downstream (memory stage) stall
- stall_o  out  1  stall to upstream
- result_o  out  32  ALU result or effective address
- reg_data1_o  out  32  registered reg_data1_i (store data)
- reg_write_o  out  2  registered writeback control
- ir_o  out  64  registered instruction
- pc_o  out  32  registered PC
- ccr_o  out  3  condition codes {C, N, Z}

## Operation
- Reset: state S_IDLE; result_o, reg_data1_o, pc_o = 0; ir_o = 64'h0; reg_write_o = 0; ccr_o = 0. The iteration counter and working registers are cleared.
- Immediate: imm = ir_i[0] ? ir_i[63:32] : sign-extend(ir_i[15:4]).
- T_ALU: B = ir_i[0] ? imm : reg_data2_i. Ops 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr (logical), 7 ashr. The shift amount is B[4:0]. Ops 8–15 produce result 0.
- Add and subtract are modulo 2^32. No flags are produced.
- T_CMP: ccr C = (A < B unsigned), N = (A < B signed), Z = (A == B), with A = reg_data1_i and B = reg_data2_i. result = A − B. Every other type holds ccr_o.
- T_LOAD / T_STORE: result = reg_data2_i + imm, modulo 2^32.
- All other types except T_MD: result = reg_data2_i.
- T_MD ops (unsigned): 0 mul (low 32 bits), 1 div, 2 mod.
  - Division by zero gives quotient 0xFFFFFFFF and remainder equal to the dividend.
  - Ops 3–15 give result 0 and still take the full latency.
- FSM S_IDLE / S_BUSY / S_DONE:
  - S_IDLE, T_MD present and stall_i = 0: latch the operands, set counter = 31, go to S_BUSY.
  - S_BUSY: one shift-add or shift-subtract step per cycle. The counter decrements each step; at counter 0 go to S_DONE.
  - S_DONE, stall_i = 0: load output registers from the T_MD result, go to S_IDLE.
  - S_DONE, stall_i = 1: hold in S_DONE.
- stall_o = stall_i | (state == S_BUSY) | (state == S_IDLE & ir_type == T_MD).
- Output register update, by condition (checked in order):
  - stall_i = 1: all output registers hold.
  - state ≠ S_DONE and stall_o = 1 because of this block: emit a bubble (ir_o = 0, reg_write_o = 0, other outputs hold).
  - Otherwise: capture the computed values.
- Iteration continues in S_BUSY regardless of stall_i.
- Reset at any point, including mid-iteration, abandons the operation and returns to the reset values immediately.

## Timing
- Single-cycle types: result is visible on the outputs one clock after presentation, when stall_i = 0.
- T_MD presented in cycle 0 (S_IDLE):
  - Cycles 1–32: S_BUSY.
  - Cycle 33: S_DONE, stall_o low (if stall_i = 0); upstream advances on that edge.
  - Result is on result_o after the cycle-33 edge: 33 cycles of stall_o high.
- stall_o is combinational from stall_i, state and ir_i. No registered stall path.
- Back-to-back T_MD: the second instruction is accepted in the S_IDLE cycle immediately following S_DONE.

## Test plan
- ADD: A = 0x7FFFFFFF, B = 1 -> result_o = 0x80000000 after 1 clock; ccr_o unchanged; stall_o = 0.
- CMP with 5 vs 7 -> ccr_o = 3'b110.
- CMP with 0xFFFFFFFF vs 1 -> ccr_o = 3'b010.
- CMP with 9 vs 9 -> ccr_o = 3'b001.
- MUL: 0x00012345 × 0x100 -> stall_o high for exactly 33 cycles; ir_o is a bubble during those cycles; result_o = 0x01234500 on the next edge.
- DIV and MOD:
  - 100 / 7 -> 0xE.
  - 100 mod 7 -> 2.
  - 0x1234 / 0 -> 0xFFFFFFFF.
  - 0x1234 mod 0 -> 0x1234.
- Downstream stall: hold stall_i = 1 for 3 cycles across LOAD, with base 0x1000 and short offset 0xFF0 (−16):
  - result_o = 0x00000FF0 and held.
  - During S_DONE with stall_i = 1, the MD result is delayed until stall_i falls.
- Reset asserted in cycle 10 of a DIV -> all outputs 0 at once, state S_IDLE, stall_o = 0 with ir_i = 0, and a following ADD completes normally.

Source files
------------

// File: rtl/execute.sv
// rtl/execute.sv - bexkat1 execute stage: ALU, address generation, compare flags, iterative mul/div/mod
module execute (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] ir_i,
    input  logic [31:0] pc_i,
    input  logic [1:0]  reg_write_i,
    input  logic [31:0] reg_data1_i,
    input  logic [31:0] reg_data2_i,
    input  logic        stall_i,
    output logic        stall_o,
    output logic [31:0] result_o,
    output logic [31:0] reg_data1_o,
    output logic [1:0]  reg_write_o,
    output logic [63:0] ir_o,
    output logic [31:0] pc_o,
    output logic [2:0]  ccr_o
);

    localparam logic [3:0] T_CMP   = 4'h3;
    localparam logic [3:0] T_MD    = 4'h6;
    localparam logic [3:0] T_ALU   = 4'h9;
    localparam logic [3:0] T_LOAD  = 4'ha;
    localparam logic [3:0] T_STORE = 4'hb;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ir_type, ir_op;
    logic [31:0] imm, alu_b, alu_result, exe_result;
    logic [2:0]  ccr_next;
    logic        is_md, self_stall, md_start;

    logic [3:0]  md_op;
    logic [4:0]  md_cnt;
    logic [31:0] md_acc, md_q, md_b, md_result;
    logic [32:0] rem_shift;
    logic        rem_geq;

    assign ir_type = ir_i[31:28];
    assign ir_op   = ir_i[27:24];
    assign is_md   = (ir_type == T_MD);
    assign imm     = ir_i[0] ? ir_i[63:32] : {{20{ir_i[15]}}, ir_i[15:4]};
    assign alu_b   = ir_i[0] ? imm : reg_data2_i;

    always_comb begin
        alu_result = 32'h0;
        case (ir_op)
            4'd0: alu_result = reg_data1_i + alu_b;
            4'd1: alu_result = reg_data1_i - alu_b;
            4'd2: alu_result = reg_data1_i & alu_b;
            4'd3: alu_result = reg_data1_i | alu_b;
            4'd4: alu_result = reg_data1_i ^ alu_b;
            4'd5: alu_result = reg_data1_i << alu_b[4:0];
            4'd6: alu_result = reg_data1_i >> alu_b[4:0];
            4'd7: alu_result = $signed(reg_data1_i) >>> alu_b[4:0];
            default: alu_result = 32'h0;
        endcase
    end

    always_comb begin
        exe_result = reg_data2_i;
        case (ir_type)
            T_ALU:          exe_result = alu_result;
            T_CMP:          exe_result = reg_data1_i - reg_data2_i;
            T_LOAD, T_STORE: exe_result = reg_data2_i + imm;
            default:        exe_result = reg_data2_i;
        endcase
    end

    assign ccr_next = {reg_data1_i < reg_data2_i,
                       $signed(reg_data1_i) < $signed(reg_data2_i),
                       reg_data1_i == reg_data2_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (is_md && !stall_i) state_d = S_BUSY;
            S_BUSY: if (md_cnt == 5'd0)    state_d = S_DONE;
            S_DONE: if (!stall_i)          state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        self_stall = (state_q == S_BUSY) || (state_q == S_IDLE && is_md);
        md_start   = (state_q == S_IDLE) && is_md && !stall_i;
        stall_o    = stall_i || self_stall;
    end

    // Restoring division: quotient bits shift into md_q as dividend bits shift out.
    assign rem_shift = {md_acc, md_q[31]};
    assign rem_geq   = rem_shift >= {1'b0, md_b};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            md_op  <= 4'h0;
            md_cnt <= 5'd0;
            md_acc <= 32'h0;
            md_q   <= 32'h0;
            md_b   <= 32'h0;
        end else if (md_start) begin
            md_op  <= ir_op;
            md_cnt <= 5'd31;
            md_acc <= 32'h0;
            md_q   <= (ir_op == 4'd0) ? reg_data2_i : reg_data1_i;
            md_b   <= (ir_op == 4'd0) ? reg_data1_i : reg_data2_i;
        end else if (state_q == S_BUSY) begin
            md_cnt <= md_cnt - 5'd1;
            if (md_op == 4'd0) begin
                if (md_q[0]) md_acc <= md_acc + md_b;
                md_b <= md_b << 1;
                md_q <= md_q >> 1;
            end else begin
                md_acc <= rem_geq ? (rem_shift[31:0] - md_b) : rem_shift[31:0];
                md_q   <= {md_q[30:0], rem_geq};
            end
        end
    end

    always_comb begin
        md_result = 32'h0;
        case (md_op)
            4'd0:    md_result = md_acc;
            4'd1:    md_result = md_q;
            4'd2:    md_result = md_acc;
            default: md_result = 32'h0;
        endcase
    end

    // In S_DONE upstream is still holding the T_MD instruction, so ir_i/pc_i belong to it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o    <= 32'h0;
            reg_data1_o <= 32'h0;
            reg_write_o <= 2'b00;
            ir_o        <= 64'h0;
            pc_o        <= 32'h0;
            ccr_o       <= 3'b000;
        end else if (stall_i) begin
            result_o    <= result_o;
        end else if (self_stall) begin
            ir_o        <= 64'h0;
            reg_write_o <= 2'b00;
        end else begin
            result_o    <= (state_q == S_DONE) ? md_result : exe_result;
            reg_data1_o <= reg_data1_i;
            reg_write_o <= reg_write_i;
            ir_o        <= ir_i;
            pc_o        <= pc_i;
            if (ir_type == T_CMP) ccr_o <= ccr_next;
        end
    end

endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - directed self-checking bench for execute
module tb_execute;

    localparam logic [3:0] T_CMP   = 4'h3;
    localparam logic [3:0] T_MD    = 4'h6;
    localparam logic [3:0] T_ALU   = 4'h9;
    localparam logic [3:0] T_LOAD  = 4'ha;
    localparam logic [3:0] T_STORE = 4'hb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] ir_i;
    logic [31:0] pc_i;
    logic [1:0]  reg_write_i;
    logic [31:0] reg_data1_i, reg_data2_i;
    logic        stall_i;
    logic        stall_o;
    logic [31:0] result_o, reg_data1_o, pc_o;
    logic [1:0]  reg_write_o;
    logic [63:0] ir_o;
    logic [2:0]  ccr_o;

    int checks = 0;
    int failures = 0;

    execute dut (
        .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i),
        .reg_write_i(reg_write_i), .reg_data1_i(reg_data1_i), .reg_data2_i(reg_data2_i),
        .stall_i(stall_i), .stall_o(stall_o), .result_o(result_o),
        .reg_data1_o(reg_data1_o), .reg_write_o(reg_write_o), .ir_o(ir_o),
        .pc_o(pc_o), .ccr_o(ccr_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] mk_ir(input logic [3:0] t, input logic [3:0] op,
                                          input logic lf, input logic [31:0] lim,
                                          input logic [11:0] sim);
        return {lim, t, op, 8'h00, sim, 3'b000, lf};
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [63:0] ir, input logic [31:0] a, input logic [31:0] b);
        ir_i        = ir;
        reg_data1_i = a;
        reg_data2_i = b;
        pc_i        = pc_i + 32'd4;
        reg_write_i = 2'b01;
    endtask

    // Presents a T_MD op and counts stall_o-high cycles; bubbles counts non-bubble ir_o seen meanwhile.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cycles, output int bad_bubbles);
        drive(mk_ir(T_MD, op, 1'b0, 32'h0, 12'h0), a, b);
        cycles = 0;
        bad_bubbles = 0;
        #1;
        while (stall_o === 1'b1 && cycles < 100) begin
            cycles++;
            @(posedge clk_i);
            #1;
            if (ir_o !== 64'h0) bad_bubbles++;
        end
        tick;
        res = result_o;
    endtask

    task automatic test_reset;
        checks++;
        if ({result_o, reg_data1_o, pc_o, ir_o, reg_write_o, ccr_o} !== 165'h0) begin
            failures++;
            $display("FAIL reset_outputs: result=%h data1=%h pc=%h ir=%h rw=%b ccr=%b required all 0",
                     result_o, reg_data1_o, pc_o, ir_o, reg_write_o, ccr_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b required 0", stall_o);
        end
    endtask

    task automatic test_cmp;
        logic [31:0] a_v [3] = '{32'd5, 32'hFFFFFFFF, 32'd9};
        logic [31:0] b_v [3] = '{32'd7, 32'd1, 32'd9};
        logic [2:0]  c_v [3] = '{3'b110, 3'b010, 3'b001};
        logic [31:0] r_v [3] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0};
        for (int i = 0; i < 3; i++) begin
            drive(mk_ir(T_CMP, 4'h0, 1'b0, 32'h0, 12'h0), a_v[i], b_v[i]);
            tick;
            checks++;
            if (ccr_o !== c_v[i]) begin
                failures++;
                $display("FAIL cmp_ccr[%0d]: got %b required %b", i, ccr_o, c_v[i]);
            end
            checks++;
            if (result_o !== r_v[i]) begin
                failures++;
                $display("FAIL cmp_result[%0d]: got %h required %h", i, result_o, r_v[i]);
            end
        end
    endtask

    task automatic test_alu;
        logic [63:0] ir;
        logic [31:0] exp_pc;
        logic [3:0]  op_v [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd9, 4'd0};
        logic [31:0] a_v  [10] = '{32'd5, 32'hF0F0, 32'hF0, 32'hFF, 32'd1, 32'd1,
                                   32'h80000000, 32'h80000000, 32'h1234, 32'd1};
        logic [31:0] b_v  [10] = '{32'd7, 32'hFF00, 32'h0F, 32'h0F, 32'd4, 32'd33,
                                   32'd31, 32'd4, 32'h5678, 32'h0};
        logic [31:0] e_v  [10] = '{32'hFFFFFFFE, 32'hF000, 32'hFF, 32'hF0, 32'h10, 32'h2,
                                   32'h1, 32'hF8000000, 32'h0, 32'h101};
        ir = mk_ir(T_ALU, 4'd0, 1'b0, 32'h0, 12'h0);
        drive(ir, 32'h7FFFFFFF, 32'd1);
        exp_pc = pc_i;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL add_stall: got %b required 0", stall_o);
        end
        tick;
        checks++;
        if (result_o !== 32'h80000000) begin
            failures++;
            $display("FAIL add_result: got %h required 80000000", result_o);
        end
        checks++;
        if (ccr_o !== 3'b001) begin
            failures++;
            $display("FAIL add_ccr_hold: got %b required 001", ccr_o);
        end
        checks++;
        if ({ir_o, pc_o, reg_write_o, reg_data1_o} !== {ir, exp_pc, 2'b01, 32'h7FFFFFFF}) begin
            failures++;
            $display("FAIL add_passthru: ir=%h pc=%h rw=%b d1=%h required ir=%h pc=%h rw=01 d1=7fffffff",
                     ir_o, pc_o, reg_write_o, reg_data1_o, ir, exp_pc);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 9) drive(mk_ir(T_ALU, op_v[i], 1'b1, 32'h100, 12'h0), a_v[i], b_v[i]);
            else        drive(mk_ir(T_ALU, op_v[i], 1'b0, 32'h0, 12'h0), a_v[i], b_v[i]);
            tick;
            checks++;
            if (result_o !== e_v[i]) begin
                failures++;
                $display("FAIL alu[%0d] op=%0d: got %h required %h", i, op_v[i], result_o, e_v[i]);
            end
        end
    endtask

    task automatic test_load_store;
        drive(mk_ir(T_LOAD, 4'h0, 1'b0, 32'h0, 12'hFF0), 32'h0, 32'h1000);
        tick;
        checks++;
        if (result_o !== 32'h00000FF0) begin
            failures++;
            $display("FAIL load_addr: got %h required 00000ff0", result_o);
        end
        drive(mk_ir(T_STORE, 4'h0, 1'b1, 32'h20, 12'h0), 32'hDEAD, 32'h1000);
        tick;
        checks++;
        if (result_o !== 32'h1020 || reg_data1_o !== 32'hDEAD) begin
            failures++;
            $display("FAIL store: addr=%h data=%h required 1020 dead", result_o, reg_data1_o);
        end
    endtask

    task automatic test_downstream_stall;
        logic [63:0] ld;
        ld = mk_ir(T_LOAD, 4'h0, 1'b0, 32'h0, 12'hFF0);
        drive(ld, 32'h0, 32'h1000);
        tick;
        stall_i = 1'b1;
        drive(mk_ir(T_ALU, 4'd0, 1'b0, 32'h0, 12'h0), 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (result_o !== 32'h00000FF0 || ir_o !== ld || stall_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: result=%h ir=%h stall=%b required 00000ff0 %h 1",
                         i, result_o, ir_o, stall_o, ld);
            end
        end
        stall_i = 1'b0;
        tick;
        checks++;
        if (result_o !== 32'd2) begin
            failures++;
            $display("FAIL stall_release: got %h required 2", result_o);
        end
    endtask

    task automatic test_mul;
        logic [31:0] res;
        int cyc, bad;
        run_md(4'd0, 32'h00012345, 32'h100, res, cyc, bad);
        checks++;
        if (cyc != 33) begin
            failures++;
            $display("FAIL mul_stall_cycles: got %0d required 33", cyc);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mul_bubble: %0d non-bubble cycles required 0", bad);
        end
        checks++;
        if (res !== 32'h01234500) begin
            failures++;
            $display("FAIL mul_result: got %h required 01234500", res);
        end
        checks++;
        if (ir_o !== mk_ir(T_MD, 4'd0, 1'b0, 32'h0, 12'h0)) begin
            failures++;
            $display("FAIL mul_ir: got %h required md ir", ir_o);
        end
        drive(64'h0, 32'h0, 32'h0);
        tick;
    endtask

    task automatic test_divmod;
        logic [31:0] res;
        int cyc, bad;
        logic [3:0]  op_v [5] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd3};
        logic [31:0] a_v  [5] = '{32'd100, 32'd100, 32'h1234, 32'h1234, 32'd77};
        logic [31:0] b_v  [5] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd5};
        logic [31:0] e_v  [5] = '{32'hE, 32'd2, 32'hFFFFFFFF, 32'h1234, 32'h0};
        for (int i = 0; i < 5; i++) begin
            run_md(op_v[i], a_v[i], b_v[i], res, cyc, bad);
            drive(64'h0, 32'h0, 32'h0);
            checks++;
            if (res !== e_v[i] || cyc != 33) begin
                failures++;
                $display("FAIL md[%0d] op=%0d: result=%h cycles=%0d required %h 33",
                         i, op_v[i], res, cyc, e_v[i]);
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1, r2;
        int c1, c2, b1, b2;
        run_md(4'd0, 32'd6, 32'd7, r1, c1, b1);
        run_md(4'd1, 32'd42, 32'd5, r2, c2, b2);
        drive(64'h0, 32'h0, 32'h0);
        checks++;
        if (r1 !== 32'd42 || c1 != 33) begin
            failures++;
            $display("FAIL b2b_first: result=%h cycles=%0d required 2a 33", r1, c1);
        end
        checks++;
        if (r2 !== 32'd8 || c2 != 33) begin
            failures++;
            $display("FAIL b2b_second: result=%h cycles=%0d required 8 33", r2, c2);
        end
        tick;
    endtask

    task automatic test_done_stall;
        logic [31:0] prev;
        prev = result_o;
        drive(mk_ir(T_MD, 4'd1, 1'b0, 32'h0, 12'h0), 32'd200, 32'd9);
        repeat (32) tick;
        stall_i = 1'b1;
        repeat (4) tick;
        checks++;
        if (result_o !== prev || stall_o !== 1'b1) begin
            failures++;
            $display("FAIL done_stall_hold: result=%h stall=%b required %h 1", result_o, stall_o, prev);
        end
        stall_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL done_stall_release: stall=%b required 0", stall_o);
        end
        tick;
        checks++;
        if (result_o !== 32'd22) begin
            failures++;
            $display("FAIL done_stall_result: got %h required 16", result_o);
        end
        drive(64'h0, 32'h0, 32'h0);
        tick;
    endtask

    task automatic test_reset_mid;
        logic [63:0] add_ir;
        drive(mk_ir(T_MD, 4'd1, 1'b0, 32'h0, 12'h0), 32'h1234, 32'd3);
        repeat (10) tick;
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({result_o, reg_data1_o, pc_o, ir_o, reg_write_o, ccr_o} !== 165'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: result=%h d1=%h pc=%h ir=%h rw=%b ccr=%b required all 0",
                     result_o, reg_data1_o, pc_o, ir_o, reg_write_o, ccr_o);
        end
        ir_i = 64'h0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stall: got %b required 0", stall_o);
        end
        #2;
        rst_i = 1'b0;
        add_ir = mk_ir(T_ALU, 4'd0, 1'b0, 32'h0, 12'h0);
        drive(add_ir, 32'd2, 32'd3);
        tick;
        checks++;
        if (result_o !== 32'd5 || ir_o !== add_ir) begin
            failures++;
            $display("FAIL reset_mid_add: result=%h ir=%h required 5 %h", result_o, ir_o, add_ir);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        ir_i        = 64'h0;
        pc_i        = 32'h0;
        reg_write_i = 2'b00;
        reg_data1_i = 32'h0;
        reg_data2_i = 32'h0;
        stall_i     = 1'b0;
        #3;
        test_reset;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        test_cmp;
        test_alu;
        test_load_store;
        test_downstream_stall;
        test_mul;
        test_divmod;
        test_back_to_back;
        test_done_stall;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
